// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared types and defaults for the clock time-set controller
package clock_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOURS   = 2'd1,
    ST_MINUTES = 2'd2
  } set_state_t;

  localparam int unsigned REPEAT_DELAY_DEFAULT = 2;
  localparam int unsigned DLY_W_DEFAULT        = 4;

endpackage

// File: rtl/clock_set_ctrl_repeat_timer.sv
// rtl/clock_set_ctrl_repeat_timer.sv - hold-delay counter and auto-repeat rate selection
module set_repeat_timer
  import clock_set_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned DLY_W        = DLY_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic start,
  input  logic run,
  input  logic fast,
  input  logic slow_stb,
  input  logic fast_stb,
  output logic repeat_stb
);

  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic             rate_stb;

  always_comb begin
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    rate_stb   = fast ? fast_stb : slow_stb;
    repeat_stb = run & rep_q & rate_stb;
    if (start) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (run && !rep_q && slow_stb) begin
      // The strobe that completes the hold delay only arms the repeat phase.
      cnt_d = cnt_q + DLY_W'(1);
      if (cnt_d == DLY_W'(REPEAT_DELAY)) begin
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - turns set buttons into hour/minute increment pulses and gates the 1 Hz tick
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned DLY_W        = DLY_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_1hz_stb,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_fast_set_db,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  output logic o_inc_hours,
  output logic o_inc_minutes,
  output logic o_clr_seconds,
  output logic o_set_active,
  output logic o_1hz_stb
);

  set_state_t state_q, state_d;
  logic       hrs_q, min_q;
  logic       hrs_lock_q, hrs_lock_d;
  logic       min_lock_q, min_lock_d;
  logic       hrs_rise, min_rise;
  logic       sel_db, held, enter;
  logic       repeat_stb;

  logic inc_hours_q, inc_hours_d;
  logic inc_minutes_q, inc_minutes_d;
  logic clr_seconds_q, clr_seconds_d;
  logic set_active_q, set_active_d;
  logic one_hz_q, one_hz_d;

  // Lock flags come out of reset set so a button held through reset needs a fresh press.
  always_comb begin
    hrs_lock_d = hrs_lock_q & i_set_hours_db;
    min_lock_d = min_lock_q & i_set_minutes_db;
    hrs_rise   = i_set_hours_db & ~hrs_q & ~hrs_lock_q;
    min_rise   = i_set_minutes_db & ~min_q & ~min_lock_q;
    case (state_q)
      ST_HOURS:   sel_db = i_set_hours_db;
      ST_MINUTES: sel_db = i_set_minutes_db;
      default:    sel_db = 1'b0;
    endcase
    held = (state_q != ST_IDLE) & sel_db;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      hrs_q      <= 1'b0;
      min_q      <= 1'b0;
      hrs_lock_q <= 1'b1;
      min_lock_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hrs_q      <= i_set_hours_db;
      min_q      <= i_set_minutes_db;
      hrs_lock_q <= hrs_lock_d;
      min_lock_q <= min_lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hrs_rise) begin
          state_d = ST_HOURS;
        end else if (min_rise) begin
          state_d = ST_MINUTES;
        end
      end
      ST_HOURS, ST_MINUTES: begin
        if (!sel_db) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  set_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .DLY_W        (DLY_W)
  ) u_repeat_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .start      (enter),
    .run        (held),
    .fast       (i_fast_set_db),
    .slow_stb   (i_slow_set_stb),
    .fast_stb   (i_fast_set_stb),
    .repeat_stb (repeat_stb)
  );

  always_comb begin
    inc_hours_d   = (enter && state_d == ST_HOURS)
                  | ((state_q == ST_HOURS) & repeat_stb);
    inc_minutes_d = (enter && state_d == ST_MINUTES)
                  | ((state_q == ST_MINUTES) & repeat_stb);
    clr_seconds_d = enter && (state_d == ST_MINUTES);
    set_active_d  = (state_d != ST_IDLE);
    one_hz_d      = i_1hz_stb & (state_q == ST_IDLE) & ~enter;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      inc_hours_q   <= 1'b0;
      inc_minutes_q <= 1'b0;
      clr_seconds_q <= 1'b0;
      set_active_q  <= 1'b0;
      one_hz_q      <= 1'b0;
    end else begin
      inc_hours_q   <= inc_hours_d;
      inc_minutes_q <= inc_minutes_d;
      clr_seconds_q <= clr_seconds_d;
      set_active_q  <= set_active_d;
      one_hz_q      <= one_hz_d;
    end
  end

  assign o_inc_hours   = inc_hours_q;
  assign o_inc_minutes = inc_minutes_q;
  assign o_clr_seconds = clr_seconds_q;
  assign o_set_active  = set_active_q;
  assign o_1hz_stb     = one_hz_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst;
  logic r_1hz, r_slow, r_fast, r_fdb, r_h, r_m;
  logic o_inc_hours, o_inc_minutes, o_clr_seconds, o_set_active, o_1hz_stb;

  int checks   = 0;
  int failures = 0;
  int cnt_h, cnt_m, cnt_c;

  // behavioural model: which field is held, how many slow strobes since entry
  int       m_field;
  int       m_nslow;
  bit       m_ph, m_pm, m_lh, m_lm;
  bit [4:0] exp_vec;

  always #5 clk = ~clk;

  clock_set_ctrl #(.REPEAT_DELAY(RD), .DLY_W(4)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_1hz_stb        (r_1hz),
    .i_slow_set_stb   (r_slow),
    .i_fast_set_stb   (r_fast),
    .i_fast_set_db    (r_fdb),
    .i_set_hours_db   (r_h),
    .i_set_minutes_db (r_m),
    .o_inc_hours      (o_inc_hours),
    .o_inc_minutes    (o_inc_minutes),
    .o_clr_seconds    (o_clr_seconds),
    .o_set_active     (o_set_active),
    .o_1hz_stb        (o_1hz_stb)
  );

  function automatic logic [31:0] out_vec();
    return {27'd0, o_inc_hours, o_inc_minutes, o_clr_seconds, o_set_active, o_1hz_stb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_field = 0;
    m_nslow = 0;
    m_ph    = 1'b0;
    m_pm    = 1'b0;
    m_lh    = 1'b1;
    m_lm    = 1'b1;
    exp_vec = '0;
  endtask

  task automatic model_step();
    bit rise_h, rise_m, sel, eh, em, ec, ehz, stb;
    eh = 0; em = 0; ec = 0; ehz = 0;
    rise_h = r_h && !m_ph && !m_lh;
    rise_m = r_m && !m_pm && !m_lm;
    if (m_field == 0) begin
      if (rise_h) begin
        m_field = 1; m_nslow = 0; eh = 1;
      end else if (rise_m) begin
        m_field = 2; m_nslow = 0; em = 1; ec = 1;
      end else begin
        ehz = r_1hz;
      end
    end else begin
      sel = (m_field == 1) ? r_h : r_m;
      if (!sel) begin
        m_field = 0;
      end else if (m_nslow >= RD) begin
        stb = r_fdb ? r_fast : r_slow;
        if (stb) begin
          if (m_field == 1) eh = 1; else em = 1;
        end
      end else if (r_slow) begin
        m_nslow++;
      end
    end
    m_ph = r_h;
    m_pm = r_m;
    m_lh = m_lh && r_h;
    m_lm = m_lm && r_m;
    exp_vec = {eh, em, ec, (m_field != 0), ehz};
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag, out_vec(), {27'd0, exp_vec});
    cnt_h += int'(o_inc_hours);
    cnt_m += int'(o_inc_minutes);
    cnt_c += int'(o_clr_seconds);
  endtask

  task automatic cyc(input logic h, input logic m, input logic f, input logic ss,
                     input logic fs, input logic hz, input string tag);
    r_h = h; r_m = m; r_fdb = f; r_slow = ss; r_fast = fs; r_1hz = hz;
    tick(tag);
  endtask

  task automatic clear_counts();
    cnt_h = 0; cnt_m = 0; cnt_c = 0;
  endtask

  // reset lands mid-cycle so the asynchronous clear is visible before any edge
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check("reset_async", out_vec(), 32'd0);
    model_reset();
    @(posedge clk);
    #1 check("reset_hold", out_vec(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r_h = 0; r_m = 0; r_fdb = 0; r_slow = 0; r_fast = 0; r_1hz = 0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1 check("reset_state", out_vec(), 32'd0);
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, "idle");

    // single hours press, release before any strobe
    clear_counts();
    cyc(1, 0, 0, 0, 0, 0, "hrs_entry");
    check("hrs_entry_pulse", {31'd0, o_inc_hours}, 32'd1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, "hrs_hold");
    cyc(0, 0, 0, 0, 0, 0, "hrs_release");
    check("hrs_release_active", {31'd0, o_set_active}, 32'd0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, "idle");
    check("hrs_press_count", cnt_h, 32'd1);
    check("hrs_press_clr", cnt_c, 32'd0);

    // minutes held across six slow strobes
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, "min_entry");
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 1, 0, 0, "min_slow_stb");
      cyc(0, 1, 0, 0, 0, 0, "min_gap");
      cyc(0, 1, 0, 0, 0, 0, "min_gap");
    end
    cyc(0, 0, 0, 0, 0, 0, "min_release");
    check("min_hold_count", cnt_m, 32'd5);
    check("min_hold_clr", cnt_c, 32'd1);
    check("min_hold_hrs", cnt_h, 32'd0);

    // hours in repeat phase at the fast rate, then back to slow
    cyc(1, 0, 0, 0, 0, 0, "fast_entry");
    for (int i = 0; i < RD; i++) begin
      cyc(1, 0, 0, 1, 0, 0, "fast_delay_stb");
      cyc(1, 0, 0, 0, 0, 0, "fast_delay_gap");
    end
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1, 0, 1, 0, "fast_stb");
      check("fast_pulse", {31'd0, o_inc_hours}, 32'd1);
      cyc(1, 0, 1, 0, 0, 0, "fast_gap");
    end
    check("fast_count", cnt_h, 32'd10);
    cyc(1, 0, 0, 0, 1, 0, "slow_again_fast_stb");
    check("slow_again_no_fast", {31'd0, o_inc_hours}, 32'd0);
    cyc(1, 0, 0, 1, 0, 0, "slow_again_slow_stb");
    check("slow_again_pulse", {31'd0, o_inc_hours}, 32'd1);
    cyc(1, 0, 1, 1, 1, 0, "release_with_stb_pre");
    cyc(0, 0, 1, 1, 1, 0, "release_with_stb");
    check("release_no_pulse", {31'd0, o_inc_hours}, 32'd0);

    // simultaneous rises, then minutes left held
    clear_counts();
    cyc(1, 1, 0, 0, 0, 0, "both_rise");
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, 0, "both_held");
    cyc(0, 1, 0, 0, 0, 0, "hrs_drop");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 0, "min_stale");
    check("both_rise_hrs", cnt_h, 32'd3);
    check("both_rise_min", cnt_m, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, "min_off");
    cyc(0, 1, 0, 0, 0, 0, "min_repress");
    check("min_repress_pulse", {31'd0, o_inc_minutes}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, "min_off");

    // 1 Hz gating
    cyc(0, 0, 0, 0, 0, 1, "hz_idle");
    check("hz_idle_pass", {31'd0, o_1hz_stb}, 32'd1);
    cyc(1, 0, 0, 0, 0, 1, "hz_entry");
    check("hz_entry_gated", {31'd0, o_1hz_stb}, 32'd0);
    cyc(1, 0, 0, 0, 0, 1, "hz_hours");
    check("hz_hours_gated", {31'd0, o_1hz_stb}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, "hz_release");

    // reset while minutes is repeating, button held through reset
    cyc(0, 1, 0, 0, 0, 0, "rst_min_entry");
    for (int i = 0; i < RD + 1; i++) begin
      cyc(0, 1, 0, 1, 0, 0, "rst_min_stb");
      cyc(0, 1, 0, 0, 0, 0, "rst_min_gap");
    end
    cyc(0, 1, 0, 1, 0, 0, "rst_min_pulse");
    check("rst_pre_pulse", {31'd0, o_inc_minutes}, 32'd1);
    apply_reset();
    clear_counts();
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0, 0, "rst_held");
    check("rst_held_count", cnt_m, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, "rst_release");
    cyc(0, 1, 0, 0, 0, 0, "rst_repress");
    check("rst_repress_pulse", {31'd0, o_inc_minutes}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, "idle");

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r_h = ~r_h;
      if ($urandom_range(0, 15) == 0) r_m = ~r_m;
      if ($urandom_range(0, 11) == 0) r_fdb = ~r_fdb;
      r_slow = ($urandom_range(0, 3) == 0);
      r_fast = ($urandom_range(0, 1) == 0);
      r_1hz  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) apply_reset();
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
